// File: rtl/inert_pkg.sv
// Shared types and command tables for the inertial-sensor SPI scheduler.
// The tables are packed so entry [0] is the first command issued.
package inert_pkg;

   typedef enum logic [2:0] {
      PWRUP,
      INIT,
      INIT_WT,
      IDLE,
      RD,
      RD_WT,
      HOST,
      HOST_WT
   } state_t;

   localparam logic [1:0] LAST_IDX = 2'd3;

   // Sensor configuration writes issued once after power-up, in order.
   localparam logic [3:0][15:0] INIT_TBL = {16'h1460, 16'h1150, 16'h1053, 16'h0D02};

   // Register reads for pitch rate low/high, then vertical accel low/high.
   localparam logic [3:0][15:0] RD_TBL = {16'hAD00, 16'hAC00, 16'hA300, 16'hA200};

endpackage

// File: rtl/inert_sync2.sv
// Two-flop synchronizer bringing the sensor's asynchronous INT into the
// SCLK domain.
module inert_sync2 (
   input  logic SCLK,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge SCLK or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         // NOTE: non-blocking, so q takes the old meta value and the chain really is two stages.
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/inert_sched.sv
// Schedules SPI traffic to an inertial sensor: power-up wait, configuration
// writes, INT-driven 4-byte reads, and single host transactions in idle gaps.
module inert_sched #(
   parameter logic [15:0] PWRUP_CYC = 16'hFFFF
) (
   input  logic        SCLK,
   input  logic        rst_n,
   input  logic        INT,
   input  logic        spi_done,
   input  logic [15:0] spi_rd,
   output logic        spi_wrt,
   output logic [15:0] spi_cmd,
   input  logic        host_req,
   input  logic [15:0] host_cmd,
   output logic        host_gnt,
   output logic        host_done,
   output logic [15:0] host_rd,
   output logic [15:0] ptch_rt,
   output logic [15:0] AZ,
   output logic        vld
);

   import inert_pkg::*;

   state_t          state;
   logic [15:0]     pwr_cnt;
   logic [1:0]      idx;
   logic [1:0]      ridx;
   logic [2:0][7:0] rd_byte;
   logic            int_s;

   inert_sync2 u_int_sync (
      .SCLK  (SCLK),
      .rst_n (rst_n),
      .d     (INT),
      .q     (int_s)
   );

   always_ff @(posedge SCLK or negedge rst_n) begin
      if (!rst_n) begin
         state     <= PWRUP;
         pwr_cnt   <= '0;
         idx       <= '0;
         ridx      <= '0;
         spi_wrt   <= 1'b0;
         spi_cmd   <= '0;
         host_gnt  <= 1'b0;
         host_done <= 1'b0;
         host_rd   <= '0;
         ptch_rt   <= '0;
         AZ        <= '0;
         vld       <= 1'b0;
         // NOTE: the byte slots are reset too, so a restart can never leak stale sensor bytes.
         rd_byte   <= '0;
      end else begin
         spi_wrt   <= 1'b0;
         host_gnt  <= 1'b0;
         host_done <= 1'b0;
         vld       <= 1'b0;

         case (state)
            PWRUP: begin
               if (pwr_cnt >= PWRUP_CYC) begin
                  state <= INIT;
                  idx   <= '0;
               end else if (pwr_cnt != 16'hFFFF) begin
                  pwr_cnt <= pwr_cnt + 16'd1;
               end
            end

            INIT: begin
               spi_wrt <= 1'b1;
               spi_cmd <= INIT_TBL[idx];
               state   <= INIT_WT;
            end

            INIT_WT: begin
               if (spi_done) begin
                  if (idx == LAST_IDX) begin
                     state <= IDLE;
                  end else begin
                     idx   <= idx + 2'd1;
                     state <= INIT;
                  end
               end
            end

            // Sensor data outranks the host whenever both are waiting.
            IDLE: begin
               if (int_s) begin
                  ridx  <= '0;
                  state <= RD;
               end else if (host_req) begin
                  host_gnt <= 1'b1;
                  spi_wrt  <= 1'b1;
                  spi_cmd  <= host_cmd;
                  state    <= HOST_WT;
               end
            end

            RD: begin
               spi_wrt <= 1'b1;
               spi_cmd <= RD_TBL[ridx];
               state   <= RD_WT;
            end

            // The last byte goes straight to the outputs so both words change together.
            RD_WT: begin
               if (spi_done) begin
                  if (ridx == LAST_IDX) begin
                     ptch_rt <= {rd_byte[1], rd_byte[0]};
                     AZ      <= {spi_rd[7:0], rd_byte[2]};
                     vld     <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     rd_byte[ridx] <= spi_rd[7:0];
                     ridx          <= ridx + 2'd1;
                     state         <= RD;
                  end
               end
            end

            HOST_WT: begin
               if (spi_done) begin
                  host_rd   <= spi_rd;
                  host_done <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inert_sched.sv
// Bench for inert_sched: a register-file sensor model answers SPI commands,
// a negedge monitor logs traffic, and directed plus random steps check results.
module tb_inert_sched;

   localparam logic [15:0] PWRUP_CYC = 16'd16;
   localparam int          BOUND     = 400;

   logic        SCLK = 1'b0;
   logic        rst_n;
   logic        INT;
   logic        spi_done;
   logic [15:0] spi_rd;
   logic        spi_wrt;
   logic [15:0] spi_cmd;
   logic        host_req;
   logic [15:0] host_cmd;
   logic        host_gnt;
   logic        host_done;
   logic [15:0] host_rd;
   logic [15:0] ptch_rt;
   logic [15:0] AZ;
   logic        vld;

   inert_sched #(.PWRUP_CYC(PWRUP_CYC)) dut (
      .SCLK      (SCLK),
      .rst_n     (rst_n),
      .INT       (INT),
      .spi_done  (spi_done),
      .spi_rd    (spi_rd),
      .spi_wrt   (spi_wrt),
      .spi_cmd   (spi_cmd),
      .host_req  (host_req),
      .host_cmd  (host_cmd),
      .host_gnt  (host_gnt),
      .host_done (host_done),
      .host_rd   (host_rd),
      .ptch_rt   (ptch_rt),
      .AZ        (AZ),
      .vld       (vld)
   );

   always #5 SCLK = ~SCLK;

   // Sensor model: each command addresses register cmd[14:8], answer is {hi, lo}.
   logic [7:0]  reg_lo [128];
   logic [7:0]  reg_hi [128];
   logic [15:0] init_tbl [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
   logic [15:0] rd_tbl   [4] = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

   function automatic logic [15:0] sensor_word(input logic [15:0] cmd);
      return {reg_hi[cmd[14:8]], reg_lo[cmd[14:8]]};
   endfunction

   initial begin
      logic [15:0] cur;
      spi_done = 1'b0;
      spi_rd   = '0;
      forever begin
         @(posedge SCLK);
         #1;
         if (rst_n === 1'b1 && spi_wrt === 1'b1) begin
            cur = spi_cmd;
            repeat ($urandom_range(2, 5)) @(posedge SCLK);
            #1;
            spi_rd   = sensor_word(cur);
            spi_done = 1'b1;
            @(posedge SCLK);
            #1;
            spi_done = 1'b0;
            spi_rd   = 16'($urandom);
         end
      end
   end

   // Monitor state, written only by the monitor process.
   int          cyc = 0;
   int          done_cnt = 0;
   int          vld_cnt = 0;
   int          gnt_cnt = 0;
   int          hd_cnt = 0;
   int          overlap = 0;
   int          partial = 0;
   int          gnt_done = 0;
   int          gnt_cyc = 0;
   int          vld_cyc = 0;
   logic        gnt_wrt = 1'b0;
   logic [15:0] gnt_cmd = '0;
   logic        outstanding = 1'b0;
   logic        prev_rst = 1'b0;
   logic [15:0] prev_p = '0;
   logic [15:0] prev_a = '0;
   logic [15:0] cmd_log [$];

   initial begin
      forever begin
         @(negedge SCLK);
         cyc++;
         if (rst_n !== 1'b1) begin
            outstanding = 1'b0;
            prev_rst    = 1'b0;
         end else begin
            if (spi_wrt === 1'b1) begin
               if (outstanding) overlap++;
               outstanding = 1'b1;
               cmd_log.push_back(spi_cmd);
            end else if (spi_done === 1'b1 && outstanding) begin
               outstanding = 1'b0;
               done_cnt++;
            end
            if (host_gnt === 1'b1) begin
               gnt_cnt++;
               gnt_done = done_cnt;
               gnt_cmd  = spi_cmd;
               gnt_wrt  = spi_wrt;
               gnt_cyc  = cyc;
            end
            if (host_done === 1'b1) hd_cnt++;
            if (vld === 1'b1) begin
               vld_cnt++;
               vld_cyc = cyc;
            end
            if (prev_rst && vld !== 1'b1 && (ptch_rt !== prev_p || AZ !== prev_a)) partial++;
            prev_rst = 1'b1;
         end
         prev_p = ptch_rt;
         prev_a = AZ;
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge SCLK);
      #1;
   endtask

   function automatic int count_of(input int which);
      case (which)
         0:       return cmd_log.size();
         1:       return vld_cnt;
         2:       return gnt_cnt;
         3:       return hd_cnt;
         default: return done_cnt;
      endcase
   endfunction

   task automatic wait_for(input string tag, input int which, input int target);
      int n = 0;
      while (count_of(which) < target && n < BOUND) begin
         tick();
         n++;
      end
      check({tag, "_timeout"}, 32'(count_of(which) >= target), 32'd1);
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_spi_wrt"},   32'(spi_wrt),   32'd0);
      check({pfx, "_spi_cmd"},   32'(spi_cmd),   32'd0);
      check({pfx, "_host_gnt"},  32'(host_gnt),  32'd0);
      check({pfx, "_host_done"}, 32'(host_done), 32'd0);
      check({pfx, "_host_rd"},   32'(host_rd),   32'd0);
      check({pfx, "_ptch_rt"},   32'(ptch_rt),   32'd0);
      check({pfx, "_AZ"},        32'(AZ),        32'd0);
      check({pfx, "_vld"},       32'(vld),       32'd0);
   endtask

   // Releases reset and checks the power-up wait and first configuration write.
   task automatic release_and_check_pwrup(input string pfx);
      int rel;
      int lb;
      rst_n = 1'b1;
      rel   = cyc;
      lb    = cmd_log.size();
      wait_for({pfx, "_first_wrt"}, 0, lb + 1);
      check({pfx, "_pwrup_wait"},
            32'((cyc - rel) >= int'(PWRUP_CYC) && (cyc - rel) <= int'(PWRUP_CYC) + 4), 32'd1);
      check({pfx, "_init_cmd0"}, 32'(cmd_log[lb]), 32'(init_tbl[0]));
   endtask

   task automatic set_bytes(input logic [7:0] b22, input logic [7:0] b23,
                            input logic [7:0] b2c, input logic [7:0] b2d);
      reg_lo[7'h22] = b22;
      reg_lo[7'h23] = b23;
      reg_lo[7'h2C] = b2c;
      reg_lo[7'h2D] = b2d;
   endtask

   task automatic run_burst(input string pfx);
      int base = cmd_log.size();
      int vb   = vld_cnt;
      INT = 1'b1;
      wait_for({pfx, "_rd_start"}, 0, base + 1);
      INT = 1'b0;
      wait_for({pfx, "_vld"}, 1, vb + 1);
      check({pfx, "_ptch_rt"}, 32'(ptch_rt), 32'({reg_lo[7'h23], reg_lo[7'h22]}));
      check({pfx, "_AZ"},      32'(AZ),      32'({reg_lo[7'h2D], reg_lo[7'h2C]}));
      for (int k = 0; k < 4; k++)
         check($sformatf("%s_rd_cmd%0d", pfx, k), 32'(cmd_log[base + k]), 32'(rd_tbl[k]));
      repeat (6) tick();
      check({pfx, "_vld_single"}, 32'(vld_cnt), 32'(vb + 1));
   endtask

   task automatic run_host(input string pfx, input logic [15:0] cmd);
      int gb = gnt_cnt;
      int hb = hd_cnt;
      host_cmd = cmd;
      host_req = 1'b1;
      wait_for({pfx, "_gnt"}, 2, gb + 1);
      host_req = 1'b0;
      check({pfx, "_gnt_cmd"}, 32'(gnt_cmd), 32'(cmd));
      check({pfx, "_gnt_wrt"}, 32'(gnt_wrt), 32'd1);
      wait_for({pfx, "_done"}, 3, hb + 1);
      check({pfx, "_host_rd"}, 32'(host_rd), 32'(sensor_word(cmd)));
      repeat (3) tick();
      check({pfx, "_done_single"}, 32'(hd_cnt), 32'(hb + 1));
   endtask

   // INT and a second host request raised together while a host transaction is in flight.
   task automatic run_contend(input string pfx, input logic [15:0] cmd_a, input logic [15:0] cmd_b);
      int gb = gnt_cnt;
      int base, vb, hb;
      host_cmd = cmd_a;
      host_req = 1'b1;
      wait_for({pfx, "_gnt_a"}, 2, gb + 1);
      base     = cmd_log.size();
      vb       = vld_cnt;
      hb       = hd_cnt;
      host_cmd = cmd_b;
      INT      = 1'b1;
      wait_for({pfx, "_rd_start"}, 0, base + 1);
      INT = 1'b0;
      wait_for({pfx, "_gnt_b"}, 2, gb + 2);
      host_req = 1'b0;
      check({pfx, "_burst_first"}, 32'(vld_cnt), 32'(vb + 1));
      check({pfx, "_order"}, 32'(gnt_cyc > vld_cyc), 32'd1);
      for (int k = 0; k < 4; k++)
         check($sformatf("%s_rd_cmd%0d", pfx, k), 32'(cmd_log[base + k]), 32'(rd_tbl[k]));
      check({pfx, "_cmd_b"}, 32'(cmd_log[base + 4]), 32'(cmd_b));
      check({pfx, "_gnt_cmd"}, 32'(gnt_cmd), 32'(cmd_b));
      check({pfx, "_ptch_rt"}, 32'(ptch_rt), 32'({reg_lo[7'h23], reg_lo[7'h22]}));
      check({pfx, "_AZ"},      32'(AZ),      32'({reg_lo[7'h2D], reg_lo[7'h2C]}));
      wait_for({pfx, "_done_b"}, 3, hb + 2);
      check({pfx, "_host_rd"}, 32'(host_rd), 32'(sensor_word(cmd_b)));
   endtask

   initial begin
      logic [15:0] hcmd;
      int          base, vb, db, gb;

      rst_n    = 1'b0;
      INT      = 1'b0;
      host_req = 1'b0;
      host_cmd = '0;
      for (int i = 0; i < 128; i++) begin
         reg_lo[i] = 8'($urandom);
         reg_hi[i] = 8'($urandom);
      end

      // Reset values, then power-up wait and configuration with a host request pending.
      repeat (3) tick();
      check_zero("reset");
      release_and_check_pwrup("pwrup");
      hcmd     = 16'($urandom);
      host_cmd = hcmd;
      host_req = 1'b1;
      gb       = gnt_cnt;
      wait_for("init_host_gnt", 2, gb + 1);
      host_req = 1'b0;
      check("init_gnt_after_4_done", 32'(gnt_done), 32'd4);
      for (int k = 0; k < 4; k++)
         check($sformatf("init_cmd%0d", k), 32'(cmd_log[k]), 32'(init_tbl[k]));
      check("init_host_cmd", 32'(cmd_log[4]), 32'(hcmd));
      wait_for("init_host_done", 3, 1);
      check("init_host_rd", 32'(host_rd), 32'(sensor_word(hcmd)));

      // Directed read burst and directed host transaction.
      set_bytes(8'h34, 8'h12, 8'h78, 8'h56);
      run_burst("burst_dir");
      check("burst_dir_ptch_const", 32'(ptch_rt), 32'h1234);
      check("burst_dir_az_const",   32'(AZ),      32'h5678);
      reg_lo[7'h0F] = 8'hD4;
      reg_hi[7'h0F] = 8'h00;
      run_host("host_dir", 16'h8F00);
      check("host_dir_const", 32'(host_rd), 32'h00D4);

      // Random mix of bursts, host transactions and contention.
      for (int it = 0; it < 8; it++) begin
         set_bytes(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         case ($urandom_range(0, 2))
            0:       run_burst($sformatf("rnd%0d_burst", it));
            1:       run_host($sformatf("rnd%0d_host", it), 16'($urandom));
            default: run_contend($sformatf("rnd%0d_cont", it), 16'($urandom), 16'($urandom));
         endcase
      end
      run_contend("cont_dir", 16'h8F00, 16'h0F55);

      // Reset while the third read is outstanding.
      set_bytes(8'h11, 8'h22, 8'h33, 8'h44);
      run_burst("pre_rst");
      base = cmd_log.size();
      vb   = vld_cnt;
      INT  = 1'b1;
      wait_for("mid_rd3", 0, base + 3);
      check("mid_rd3_cmd", 32'(cmd_log[base + 2]), 32'hAC00);
      INT   = 1'b0;
      rst_n = 1'b0;
      #1;
      check_zero("mid_rst");
      repeat (3) tick();
      db = done_cnt;
      release_and_check_pwrup("re_pwrup");
      wait_for("re_init_done", 4, db + 4);
      repeat (6) tick();
      check("re_no_vld", 32'(vld_cnt), 32'(vb));
      check("re_ptch_zero", 32'(ptch_rt), 32'd0);
      check("re_az_zero", 32'(AZ), 32'd0);
      set_bytes(8'h9A, 8'hBC, 8'hDE, 8'hF0);
      run_burst("post_rst");

      check("no_overlap", 32'(overlap), 32'd0);
      check("no_partial", 32'(partial), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/inert_sched.md
INERT_SCHED -- requirements
Module: inert_sched

Interface
REQ-001 SHALL have parameter PWRUP_CYC, default 16'hFFFF, meaning SCLK cycles to wait after reset before the first SPI transaction.
REQ-002 SHALL have ports (name direction width meaning):
- SCLK  in  1  block clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- INT  in  1  asynchronous data-ready from the inertial sensor.
- spi_done  in  1  one-cycle pulse from the SPI master: transaction complete.
- spi_rd  in  16  SPI master receive word; valid when spi_done is high.
- spi_wrt  out  1  one-cycle pulse that starts an SPI transaction.
- spi_cmd  out  16  command word; stable from spi_wrt through spi_done.
- host_req  in  1  host request for a single SPI transaction.
- host_cmd  in  16  host command word; sampled at grant.
- host_gnt  out  1  one-cycle grant pulse.
- host_done  out  1  one-cycle pulse when the host transaction completes.
- host_rd  out  16  host receive word; held until the next host_done.
- ptch_rt  out  16  pitch rate, {byte 0x23, byte 0x22}.
- AZ  out  16  vertical acceleration, {byte 0x2D, byte 0x2C}.
- vld  out  1  one-cycle pulse when ptch_rt and AZ have updated.

Function
REQ-003 INT SHALL be double-flopped on SCLK before use.
REQ-004 The state machine SHALL have states PWRUP, INIT, INIT_WT, IDLE, RD, RD_WT, HOST, HOST_WT.
REQ-005 PWRUP SHALL count to PWRUP_CYC and then go to INIT with idx=0.
REQ-006 INIT SHALL issue spi_wrt with spi_cmd = INIT_TBL[idx] and go to INIT_WT.
- INIT_TBL = 16'h0D02, 16'h1053, 16'h1150, 16'h1460.
REQ-007 INIT_WT SHALL wait for spi_done and then take one of two paths.
- idx<3: idx+1, return to INIT.
- idx=3: go to IDLE.
REQ-008 Host requests SHALL be ignored (no grant) in PWRUP, INIT and INIT_WT.
REQ-009 In IDLE with synchronized INT high, the machine SHALL go to RD with ridx=0, ahead of any pending host_req.
REQ-010 In IDLE with INT low and host_req high, the machine SHALL do the following:
- pulse host_gnt;
- latch host_cmd onto spi_cmd;
- pulse spi_wrt in the same cycle;
- go to HOST_WT.
REQ-011 RD SHALL issue spi_cmd = RD_TBL[ridx] and go to RD_WT.
- RD_TBL = 16'hA200, 16'hA300, 16'hAC00, 16'hAD00.
REQ-012 RD_WT SHALL latch spi_rd[7:0] into byte slot ridx on spi_done.
- ridx<3: ridx+1, return to RD.
- ridx=3: go to IDLE.
REQ-013 On the ridx=3 spi_done, ptch_rt and AZ SHALL update together on the next edge, with vld pulsing high for that one cycle.
- Partial results SHALL never appear on ptch_rt or AZ.
REQ-014 HOST_WT SHALL latch spi_rd into host_rd on spi_done, pulse host_done on the next cycle, and go to IDLE.
REQ-015 spi_wrt SHALL never be asserted while a transaction is outstanding (any _WT state).
REQ-016 INT rising during RD/RD_WT/HOST/HOST_WT SHALL be serviced on the first IDLE cycle if still high; no event counting.
REQ-017 spi_done arriving outside a _WT state SHALL be ignored.
REQ-018 The PWRUP counter SHALL saturate, with no wrap-around.
REQ-019 ridx and idx SHALL be 2-bit.

Reset
REQ-020 rst_n low SHALL force the following, regardless of any in-flight transaction:
- state PWRUP;
- counters, idx and ridx to 0;
- spi_wrt, host_gnt, host_done and vld to 0;
- spi_cmd, ptch_rt, AZ, host_rd and the byte slots to 16'h0000;
- INT synchronizer flops to 0.
REQ-021 Deassertion of rst_n mid-transaction SHALL restart the full PWRUP and INIT sequence.

Structure
REQ-022 The state enum, INIT_TBL and RD_TBL SHALL reside in shared package inert_pkg.
REQ-023 The block SHALL instantiate one sub-module, inert_sync2, the 2-flop synchronizer for INT; the SPI master remains external.

Verification
REQ-024 The bench SHALL cover these directed scenarios (PWRUP_CYC=16 in the bench):
- Reset, then 16 cycles -> spi_wrt with 0x0D02; after 4 spi_done pulses -> commands were 0D02, 1053, 1150, 1460 in order, then IDLE.
- INT high; SPI model returns 0x34, 0x12, 0x78, 0x56 -> commands A200, A300, AC00, AD00; single vld pulse with ptch_rt=16'h1234, AZ=16'h5678.
- host_req with host_cmd=16'h8F00 in IDLE; model returns 16'h00D4 -> host_gnt pulse, spi_cmd=8F00, host_done pulse with host_rd=16'h00D4.
- INT and host_req raised in the same cycle -> 4-read burst first, then host grant; never two spi_wrt without an intervening spi_done.
- host_req during INIT -> no host_gnt until after the 4th init spi_done.
- rst_n pulsed low during RD_WT at ridx=2 -> all outputs 0 immediately, no vld, PWRUP restarts, previous ptch_rt/AZ not restored.
